// File: rtl/instr_loader_if.sv
// instr_loader_if: groups the loader's byte-stream input and instruction-memory write port.
// Signals: byte_valid/byte_data/byte_ready (valid/ready byte stream, LSB of each word first),
//          imem_we/imem_addr/imem_wdata (one-cycle write strobe with word address and data).
// master = loader view (consumes bytes, drives memory writes); slave = the opposite side.
interface instr_loader_if #(
  parameter int ADDR_W = 8
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_loader.sv
// instr_loader: packs a little-endian byte stream into 32-bit words and writes them to
// consecutive instruction-memory addresses while holding the core in reset; counts words
// whose opcode the main decoder does not support (saturating).
// Ports: clk, rst_n (sync, active low), start/len_words (load request), bus (byte stream in,
//        imem write out), core_rst_n, busy, done, illegal_cnt.
// Latency: last byte of a word at N -> imem_we at N+1; for the last word, done/core_rst_n at N+2.
// Backpressure: byte_ready is high only while receiving; stalls on byte_valid are unbounded.
module instr_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len_words,
  instr_loader_if.master    bus,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   illegal_cnt
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  // Memory capacity in words; longer requests are clamped so the address never wraps.
  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_nxt;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   len_clamped;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        byte_idx;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   cnt_q;
  logic              start_ok;
  logic              xfer;
  logic              last_word;
  logic              ready_c;
  logic              we_c;

  function automatic logic opcode_ok(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0100011, 7'b0110011,
      7'b1100011, 7'b0010011, 7'b1101111: opcode_ok = 1'b1;
      default:                            opcode_ok = 1'b0;
    endcase
  endfunction

  assign len_clamped = (len_words > CAP) ? CAP : len_words;
  assign start_ok    = start && ((state == IDLE) || (state == DONE));
  assign xfer        = bus.byte_valid && ready_c;
  // len_q is never 0 outside IDLE/DONE, so len_q-1 does not underflow when this is used.
  assign last_word   = ({1'b0, word_idx} == (len_q - 1'b1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (len_clamped == '0) ? DONE : RECV;
      RECV:       if (xfer && (byte_idx == 2'd3)) state_nxt = WRITE;
      WRITE:      state_nxt = last_word ? DONE : RECV;
      default:    state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    ready_c    = 1'b0;
    we_c       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    core_rst_n = 1'b0;
    case (state)
      RECV:  begin ready_c = 1'b1; busy = 1'b1; end
      WRITE: begin we_c = 1'b1; busy = 1'b1; end
      DONE:  begin done = 1'b1; core_rst_n = 1'b1; end
      default: ;
    endcase
  end

  // Datapath: length latch, word/byte indices, word assembly, write address, opcode screen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q    <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      wdata_q  <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
    end else begin
      if (start_ok) begin
        len_q    <= len_clamped;
        word_idx <= '0;
        byte_idx <= '0;
        cnt_q    <= '0;
      end
      if ((state == RECV) && xfer) begin
        wdata_q[{byte_idx, 3'b000} +: 8] <= bus.byte_data;
        byte_idx <= byte_idx + 2'd1;  // wraps to 0 after the fourth byte
        // Address is captured with the final byte so it is stable during the write cycle
        // and then holds until the next word is written.
        if (byte_idx == 2'd3) addr_q <= word_idx;
      end
      if (state == WRITE) begin
        if (!opcode_ok(wdata_q[6:0]) && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
        if (!last_word) begin
          word_idx <= word_idx + 1'b1;
          byte_idx <= '0;
        end
      end
    end
  end

  assign bus.byte_ready = ready_c;
  assign bus.imem_we    = we_c;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign illegal_cnt    = cnt_q;

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized and directed loads against an event-based reference model.
module tb_instr_loader;
  localparam int AW  = 2;
  localparam int CAP = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   len_words = '0;
  logic          core_rst_n, busy, done;
  logic [AW:0]   illegal_cnt;

  instr_loader_if #(.ADDR_W(AW)) bus ();

  instr_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len_words  (len_words),
    .bus        (bus),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit legal(input logic [6:0] op);
    return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011, 7'b1101111};
  endfunction

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  // Reference model: writes expected from accepted bytes, timed by cycle stamps.
  int          cyc = 0;
  bit          armed = 0;
  bit          m_ld = 0;
  bit          m_done = 0;
  int          we_due = -1;
  int          m_len = 0, m_words = 0, m_bytes = 0;
  logic [31:0] m_word = '0;
  logic [AW:0] m_cnt = '0;
  int          last_addr = 0;
  logic [31:0] last_data = '0;
  wr_t         exp_q[$];
  wr_t         wlog[$];

  always @(negedge clk) begin
    bit  exp_we, exp_rdy;
    wr_t w;
    cyc++;
    exp_we  = (cyc == we_due);
    exp_rdy = m_ld && !exp_we;
    if (bus.imem_we === 1'b1) wlog.push_back('{int'(bus.imem_addr), bus.imem_wdata});
    if (armed) begin
      chk("imem_we", 32'(bus.imem_we), 32'(exp_we));
      chk("byte_ready", 32'(bus.byte_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(m_ld));
      chk("done", 32'(done), 32'(m_done));
      chk("core_rst_n", 32'(core_rst_n), 32'(m_done));
      chk("illegal_cnt", 32'(illegal_cnt), 32'(m_cnt));
      if (exp_we) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL model_queue: write due with no expected word");
        end else begin
          chk("imem_addr", 32'(bus.imem_addr), 32'(exp_q[0].addr));
          chk("imem_wdata", bus.imem_wdata, exp_q[0].data);
        end
      end else begin
        chk("imem_addr_hold", 32'(bus.imem_addr), 32'(last_addr));
        if (!m_ld) chk("imem_wdata_hold", bus.imem_wdata, last_data);
      end
    end
    // Expectations for the next cycle
    if (!rst_n) begin
      armed = 1; m_ld = 0; m_done = 0; we_due = -1; m_cnt = '0;
      last_addr = 0; last_data = '0; m_bytes = 0; m_words = 0; m_len = 0;
      exp_q.delete();
    end else if (armed) begin
      if (exp_we && exp_q.size() != 0) begin
        w = exp_q.pop_front();
        if (!legal(w.data[6:0]) && m_cnt != '1) m_cnt = m_cnt + 1'b1;
        last_addr = w.addr;
        last_data = w.data;
        if (m_words == m_len) begin m_ld = 0; m_done = 1; end
      end
      if (exp_rdy && bus.byte_valid) begin
        m_word[8*m_bytes +: 8] = bus.byte_data;
        m_bytes++;
        if (m_bytes == 4) begin
          exp_q.push_back('{m_words, m_word});
          m_words++;
          m_bytes = 0;
          we_due = cyc + 1;
        end
      end
      if (start && !m_ld) begin
        m_len = (int'(len_words) > CAP) ? CAP : int'(len_words);
        m_cnt = '0; m_words = 0; m_bytes = 0;
        exp_q.delete();
        if (m_len == 0) m_done = 1;
        else begin m_ld = 1; m_done = 0; end
      end
    end
  end

  // Stimulus helpers (inputs change 2 time units after a rising edge)
  task automatic do_reset();
    @(posedge clk); #2; rst_n = 1'b0; start = 1'b0; bus.byte_valid = 1'b0;
    @(posedge clk); #2; rst_n = 1'b1;
  endtask

  task automatic pulse_start(input int len);
    @(posedge clk); #2; start = 1'b1; len_words = len[AW:0];
    @(posedge clk); #2; start = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] b[$], input int stall_pct, input bit glitch,
                            input int stall_idx, input int stall_len);
    for (int i = 0; i < b.size(); i++) begin
      int guard;
      bit ok;
      guard = 0;
      ok = 0;
      if (i == stall_idx) begin
        repeat (stall_len) begin
          bus.byte_valid = 1'b0; bus.byte_data = 8'($urandom); start = 1'b0;
          @(posedge clk); #2;
        end
      end
      while ($urandom_range(99) < stall_pct) begin
        bus.byte_valid = 1'b0; start = 1'b0;
        @(posedge clk); #2;
      end
      bus.byte_valid = 1'b1;
      bus.byte_data  = b[i];
      do begin
        if (glitch) begin
          start = ($urandom_range(3) == 0);
          len_words = (AW+1)'($urandom);
        end
        @(negedge clk); ok = bus.byte_ready;
        @(posedge clk); #2;
        guard++;
      end while (!ok && guard < 50);
      if (!ok) begin
        checks++; errors++;
        $display("FAIL byte_accept_timeout: byte %0d not accepted within 50 cycles", i);
        break;
      end
    end
    bus.byte_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    do begin @(negedge clk); g++; end while (!done && g < 200);
    chk("done_reached", 32'(done), 32'd1);
  endtask

  task automatic load(input int len, input logic [31:0] words[$], input int stall_pct,
                      input bit glitch, input int stall_idx, input int stall_len);
    logic [7:0] b[$];
    int n;
    n = (len > CAP) ? CAP : len;
    for (int w = 0; w < n; w++)
      for (int k = 0; k < 4; k++) b.push_back(words[w][8*k +: 8]);
    wlog.delete();
    pulse_start(len);
    send_bytes(b, stall_pct, glitch, stall_idx, stall_len);
    wait_done();
  endtask

  task automatic check_log(input string tag, input logic [31:0] exp_d[$]);
    chk({tag, "_nwrites"}, 32'(wlog.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < wlog.size(); i++) begin
      chk({tag, "_addr"}, 32'(wlog[i].addr), 32'(i));
      chk({tag, "_data"}, wlog[i].data, exp_d[i]);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [6:0] ops[6];
    logic [31:0] w;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011, 7'b1101111};
    w = $urandom;
    if ($urandom_range(1) == 0) w[6:0] = ops[$urandom_range(5)];
    return w;
  endfunction

  initial begin
    logic [31:0] prog[$];
    logic [31:0] rnd[$];
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_wdata", bus.imem_wdata, 32'd0);

    // Bytes offered in IDLE must not be taken
    @(posedge clk); #2; bus.byte_valid = 1'b1; bus.byte_data = 8'hAA;
    repeat (3) @(posedge clk);
    #2; bus.byte_valid = 1'b0;

    // Two-word program: addi, lw
    prog = '{32'h00A00513, 32'h00402283};
    load(2, prog, 0, 0, -1, 0);
    check_log("t1", prog);
    chk("t1_illegal", 32'(illegal_cnt), 32'd0);
    chk("t1_core_rst_n", 32'(core_rst_n), 32'd1);

    // Same program with a 5-cycle gap before the third byte
    load(2, prog, 0, 0, 2, 5);
    check_log("t2", prog);

    // Illegal opcode counted, jal not
    load(1, '{32'hFFFFFFFF}, 0, 0, -1, 0);
    chk("t3_illegal_ff", 32'(illegal_cnt), 32'd1);
    load(1, '{32'h0000006F}, 0, 0, -1, 0);
    chk("t3_illegal_jal", 32'(illegal_cnt), 32'd0);

    // Zero-length load from IDLE
    do_reset();
    wlog.delete();
    pulse_start(0);
    @(negedge clk);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_core_rst_n", 32'(core_rst_n), 32'd1);
    chk("t4_nwrites", 32'(wlog.size()), 32'd0);

    // Oversized length clamps to 4 words; start pulses while busy are ignored
    prog = '{32'h00000013, 32'h00000023, 32'h00000033, 32'h00000063};
    load(7, prog, 20, 1, -1, 0);
    check_log("t5", prog);

    // Reset mid-load after two bytes of word 1
    wlog.delete();
    pulse_start(2);
    send_bytes('{8'h13, 8'h05, 8'hA0, 8'h00, 8'h83, 8'h22}, 0, 0, -1, 0);
    do_reset();
    @(negedge clk);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_ready", 32'(bus.byte_ready), 32'd0);
    chk("t6_wdata", bus.imem_wdata, 32'd0);
    chk("t6_nwrites", 32'(wlog.size()), 32'd1);
    prog = '{32'h00402283};
    load(1, prog, 0, 0, -1, 0);
    check_log("t6b", prog);

    // Randomized loads
    for (int it = 0; it < 25; it++) begin
      int len;
      int n;
      rnd.delete();
      len = $urandom_range(0, 7);
      n = (len > CAP) ? CAP : len;
      for (int w = 0; w < n; w++) rnd.push_back(rand_word());
      if ($urandom_range(1) == 1) begin
        @(posedge clk); #2; bus.byte_valid = 1'b1; bus.byte_data = 8'($urandom);
        repeat (2) @(posedge clk);
        #2; bus.byte_valid = 1'b0;
      end
      load(len, rnd, $urandom_range(0, 40), bit'($urandom_range(1)), -1, 0);
      check_log("rand", rnd);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
